// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory: access sizes, FSM states
// and the byte count of each access size.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  localparam int CNT_W = 4;

  // ILLEGAL reports 4 bytes; such accesses are rejected before they touch the array.
  function automatic logic [2:0] size_bytes(input mem_size_t size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_format.sv
// Byte-lane steering between the 32-bit data path and the four byte banks:
// store byte enables / lane data, and load assembly with sign or zero extension.
module dmem_lane_format
  import dmem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  mem_size_t   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byte_en,
  output logic [31:0] st_lane_data,
  input  mem_size_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_lane_data,
  output logic [31:0] ld_data
);

  logic [2:0]  st_n;
  logic [2:0]  ld_n;
  logic [31:0] ld_asm;

  assign st_n = size_bytes(st_size);
  assign ld_n = size_bytes(ld_size);

  // Lane gi holds the byte at word offset gi; st_k is its position inside the access.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [2:0] st_k;
    logic [1:0] st_src;
    logic [1:0] ld_src;

    assign st_k                    = 3'(gi) - {1'b0, st_off};
    assign st_src                  = BIG_ENDIAN ? 2'(st_n - 3'd1 - st_k) : st_k[1:0];
    assign st_byte_en[gi]          = (st_k < st_n);
    assign st_lane_data[8*gi +: 8] = st_wdata[8*st_src +: 8];

    assign ld_src = BIG_ENDIAN ? 2'(3'(ld_off) + ld_n - 3'd1 - 3'(gi))
                               : 2'(ld_off + 2'(gi));
    assign ld_asm[8*gi +: 8] = ld_lane_data[8*ld_src +: 8];
  end

  always_comb begin
    ld_data = ld_asm;
    case (ld_size)
      BYTE:    ld_data = {{24{~ld_unsigned & ld_asm[7]}}, ld_asm[7:0]};
      HALF:    ld_data = {{16{~ld_unsigned & ld_asm[15]}}, ld_asm[15:0]};
      default: ld_data = ld_asm;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with byte/half/word accesses, fixed access latency
// and a valid/ready request, one-cycle response pulse interface.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 8192,
  parameter int LATENCY     = 1,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  mem_size_t        size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rdata_vld_q, rdata_vld_d;
  mem_size_t        ld_size_q, ld_size_d;
  logic             ld_uns_q, ld_uns_d;
  logic [1:0]       ld_off_q, ld_off_d;

  logic             accept;
  logic             commit;
  logic             acc_error;
  logic [32:0]      last_byte;
  logic             do_write;
  logic             do_read;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       byte_en;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_rdata;
  logic [31:0]      load_data;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (state_q == WAIT) && (cnt_q == '0);
  assign word_idx  = addr_q[IDX_W+1:2];

  // End address in 33 bits so an access near 2^32 cannot wrap back into range.
  always_comb begin
    last_byte = {1'b0, addr_q} + 33'(size_bytes(size_q)) - 33'd1;
    acc_error = (size_q == ILLEGAL)
             || ((size_q == HALF) && addr_q[0])
             || ((size_q == WORD) && (addr_q[1:0] != 2'b00))
             || (last_byte >= 33'(DEPTH_BYTES));
  end

  assign do_write = commit && !acc_error && wr_q;
  assign do_read  = commit && !acc_error && !wr_q;

  dmem_lane_format #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_format (
    .st_size      (size_q),
    .st_off       (addr_q[1:0]),
    .st_wdata     (wdata_q),
    .st_byte_en   (byte_en),
    .st_lane_data (lane_wdata),
    .ld_size      (ld_size_q),
    .ld_off       (ld_off_q),
    .ld_unsigned  (ld_uns_q),
    .ld_lane_data (lane_rdata),
    .ld_data      (load_data)
  );

  // One byte-wide bank per lane keeps each bank a plain RAM with a registered read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [7:0] bank [WORDS];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk) begin
      if (do_write && byte_en[gi]) begin
        bank[word_idx] <= lane_wdata[8*gi +: 8];
      end
      if (do_read) begin
        rd_byte_q <= bank[word_idx];
      end
    end

    assign lane_rdata[8*gi +: 8] = rd_byte_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rdata_vld_d = rdata_vld_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    ld_off_d    = ld_off_q;

    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_error_d = acc_error;
          rdata_vld_d = do_read;
          if (do_read) begin
            ld_size_d = size_q;
            ld_uns_d  = uns_q;
            ld_off_d  = addr_q[1:0];
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = accept ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      wr_d    = req_write;
      size_d  = mem_size_t'(req_size);
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = CNT_W'(LATENCY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      size_q      <= BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_vld_q <= 1'b0;
      ld_size_q   <= BYTE;
      ld_uns_q    <= 1'b0;
      ld_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rdata_vld_q <= rdata_vld_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      ld_off_q    <= ld_off_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rdata_vld_q ? load_data : 32'h0;

endmodule

// File: tb/tb_sized_data_memory.sv
// Scoreboard bench: four DUT configurations (LE/lat1, BE/lat1, LE/lat0, LE/lat3)
// exercised one at a time; expected responses are queued at accept and checked on rsp_valid.
module tb_sized_data_memory;

  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n_a;
  logic [3:0]       req_valid_a;
  logic [3:0]       ready_a;
  logic [3:0]       valid_a;
  logic [3:0]       error_a;
  logic [3:0][31:0] rdata_a;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sized_data_memory #(
      .DEPTH_BYTES (DEPTH),
      .LATENCY     ((gi == 2) ? 0 : ((gi == 3) ? 3 : 1)),
      .BIG_ENDIAN  (gi == 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n_a[gi]),
      .req_valid    (req_valid_a[gi]),
      .req_ready    (ready_a[gi]),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (valid_a[gi]),
      .rsp_rdata    (rdata_a[gi]),
      .rsp_error    (error_a[gi])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   sel = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 2) ? 0 : ((u == 3) ? 3 : 1);
  endfunction

  always @(negedge clk) begin
    if (valid_a[sel]) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn u%0d cyc=%0d rdata=0x%08h err=%0b exp_rdata=0x%08h exp_err=%0b",
                 sel, cyc, rdata_a[sel], error_a[sel], mon_e.rdata, mon_e.err);
        check("rsp_rdata", rdata_a[sel], mon_e.rdata);
        check("rsp_error", 32'(error_a[sel]), 32'(mon_e.err));
        check("rsp_cycle", cyc, mon_e.due);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input int u, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit hold, input bit push);
    int n = 0;
    req_write      = wr;
    req_size       = sz;
    req_unsigned   = uns;
    req_addr       = addr;
    req_wdata      = wdata;
    req_valid_a[u] = 1'b1;
    while (!ready_a[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a[u]) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid_a[u] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    prev_acc = last_acc;
    last_acc = cyc;
    if (push) exp_q.push_back('{exp_rd, exp_err, cyc + lat_of(u) + 1});
    check("ready_after_accept", 32'(ready_a[u]), 32'd0);
    if (!hold) req_valid_a[u] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_a      = 4'h0;
    req_valid_a  = 4'h0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_a[0]), 32'd1);
    check("rst_valid", 32'(valid_a[0]), 32'd0);
    check("rst_rdata", rdata_a[0], 32'h0);
    check("rst_error", 32'(error_a[0]), 32'd0);
    rst_n_a = 4'hF;
    @(negedge clk);

    // Little-endian, latency 1
    sel = 0;
    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 1);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0, 1);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0, 0, 1);
    issue(0, 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 0, 1);
    issue(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000DEAD, 0, 0, 1);
    issue(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF55, 32'h0, 0, 0, 1);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0, 1);
    issue(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 0, 1);
    issue(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 0, 1);
    issue(0, 1, 2'b01, 0, 32'h21, 32'h0000AAAA, 32'h0, 1, 0, 1);
    issue(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 0, 1);
    issue(0, 1, 2'b11, 0, 32'h20, 32'h0, 32'h0, 1, 0, 1);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, 0, 1);
    issue(0, 1, 2'b10, 0, DEPTH - 4, 32'hCAFEF00D, 32'h0, 0, 0, 1);
    issue(0, 1, 2'b10, 0, DEPTH - 2, 32'hFFFFFFFF, 32'h0, 1, 0, 1);
    issue(0, 0, 2'b10, 0, DEPTH - 4, 32'h0, 32'hCAFEF00D, 0, 0, 1);
    issue(0, 1, 2'b00, 0, DEPTH - 1, 32'h00000077, 32'h0, 0, 0, 1);
    issue(0, 0, 2'b10, 0, DEPTH - 4, 32'h0, 32'h77FEF00D, 0, 0, 1);
    issue(0, 0, 2'b00, 0, DEPTH, 32'h0, 32'h0, 1, 0, 1);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0, 1);
    drain();

    // Big-endian, latency 1
    sel = 1;
    issue(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 1);
    issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    issue(1, 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFDE, 0, 0, 1);
    issue(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000BEEF, 0, 0, 1);
    issue(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000EF, 0, 0, 1);
    issue(1, 1, 2'b00, 0, 32'h11, 32'h00000055, 32'h0, 0, 0, 1);
    issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, 0, 1);
    issue(1, 1, 2'b01, 0, 32'h10, 32'h00001234, 32'h0, 0, 0, 1);
    issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0, 0, 1);
    drain();

    // Latency 0, requests held valid back to back
    sel = 2;
    issue(2, 1, 2'b10, 0, 32'h0, 32'h01020304, 32'h0, 0, 1, 1);
    issue(2, 0, 2'b10, 0, 32'h0, 32'h0, 32'h01020304, 0, 1, 1);
    check("b2b_spacing", last_acc - prev_acc, 32'd2);
    issue(2, 0, 2'b00, 1, 32'h1, 32'h0, 32'h00000003, 0, 1, 1);
    check("b2b_spacing", last_acc - prev_acc, 32'd2);
    issue(2, 0, 2'b01, 0, 32'h2, 32'h0, 32'h00000102, 0, 1, 1);
    check("b2b_spacing", last_acc - prev_acc, 32'd2);
    issue(2, 0, 2'b00, 0, 32'h3, 32'h0, 32'h00000001, 0, 0, 1);
    check("b2b_spacing", last_acc - prev_acc, 32'd2);
    drain();

    // Latency 3, reset pulsed while a store waits
    sel = 3;
    issue(3, 1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0, 0, 1);
    issue(3, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0, 0, 1);
    drain();
    issue(3, 1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0, 0, 0);
    rst_n_a[3] = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_a[3]), 32'd1);
    check("midrst_valid", 32'(valid_a[3]), 32'd0);
    check("midrst_rdata", rdata_a[3], 32'h0);
    check("midrst_error", 32'(error_a[3]), 32'd0);
    repeat (6) @(negedge clk);
    rst_n_a[3] = 1'b1;
    @(negedge clk);
    issue(3, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0, 0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
